// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive paths on the Bridge device bus.
package uart_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam int STAT_BUSY      = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_EMPTY     = 2;
   localparam int STAT_OVERRUN   = 3;
   localparam int STAT_COUNT_LSB = 4;

   localparam logic [15:0] DIV_MIN = 16'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   // A divisor below two cannot hold a bit long enough to reload the counter.
   function automatic logic [15:0] clamp_div(input logic [15:0] value);
      return (value < DIV_MIN) ? DIV_MIN : value;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter; fullness and emptiness are judged on the
// pre-edge count, so a push into a full FIFO is dropped even if a pop happens on that edge.
module uart_tx_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    din,
   output logic [7:0]    dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign full      = (count_r == FULL_CNT);
   assign empty     = (count_r == '0);
   assign count     = count_r;
   assign dout      = mem_r[rd_ptr_r];
   assign push_ok_s = push && !full;
   assign pop_ok_s  = pop && !empty;

   // Storage array; no reset needed since contents are only read behind the count.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + (AW + 1)'(1'b1);
            2'b01:   count_r <= count_r - (AW + 1)'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// Bus-mapped 8N1 UART transmitter: byte FIFO, programmable baud divisor and
// a level interrupt raised once every queued byte has left the wire.
module uart_tx
   import uart_pkg::*;
#(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd217
) (
   input  logic        clk_in,
   input  logic        sys_rstn,
   input  logic        TX_WE,
   input  logic [31:0] TX_Addr,
   input  logic [31:0] TX_WriteData,
   output logic [31:0] TX_ReadData,
   output logic        TX_IRQ,
   output logic        uart_txd
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_e    state_r;
   logic [7:0]   shift_r;
   logic [2:0]   bit_idx_r;
   logic [15:0]  bit_cnt_r;
   logic         txd_r;
   logic         irq_r;
   logic [15:0]  div_r;
   logic         ie_r;
   logic         overrun_r;

   logic [1:0]   reg_sel_s;
   logic         push_s;
   logic         pop_s;
   logic [7:0]   fifo_dout_s;
   logic         fifo_full_s;
   logic         fifo_empty_s;
   logic [CW-1:0] fifo_count_s;
   logic [31:0]  rd_data_s;
   logic         unused_s;

   assign reg_sel_s   = TX_Addr[3:2];
   assign push_s      = TX_WE && (reg_sel_s == REG_DATA);
   assign uart_txd    = txd_r;
   assign TX_IRQ      = irq_r;
   assign TX_ReadData = rd_data_s;
   assign unused_s    = ^{TX_Addr[31:4], TX_Addr[1:0], TX_WriteData[31:16]};

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_in),
      .rst_n (sys_rstn),
      .push  (push_s),
      .pop   (pop_s),
      .din   (TX_WriteData[7:0]),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   // Pop request: from IDLE, or at the end of a stop bit so frames run back to back.
   always_comb begin
      pop_s = 1'b0;
      case (state_r)
         ST_IDLE: pop_s = !fifo_empty_s;
         ST_STOP: begin
            if (bit_cnt_r == 16'd0) begin
               pop_s = !fifo_empty_s;
            end else begin
               pop_s = 1'b0;
            end
         end
         default: pop_s = 1'b0;
      endcase
   end

   // Serialiser FSM; DIV is sampled on every bit-counter reload.
   always_ff @(posedge clk_in) begin
      if (!sys_rstn) begin
         state_r   <= ST_IDLE;
         shift_r   <= 8'd0;
         bit_idx_r <= 3'd0;
         bit_cnt_r <= 16'd0;
         txd_r     <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               txd_r <= 1'b1;
               if (pop_s) begin
                  shift_r   <= fifo_dout_s;
                  bit_cnt_r <= div_r - 16'd1;
                  txd_r     <= 1'b0;
                  state_r   <= ST_START;
               end
            end
            ST_START: begin
               if (bit_cnt_r == 16'd0) begin
                  state_r   <= ST_DATA;
                  bit_idx_r <= 3'd0;
                  txd_r     <= shift_r[0];
                  bit_cnt_r <= div_r - 16'd1;
               end else begin
                  bit_cnt_r <= bit_cnt_r - 16'd1;
               end
            end
            ST_DATA: begin
               if (bit_cnt_r == 16'd0) begin
                  bit_cnt_r <= div_r - 16'd1;
                  if (bit_idx_r == 3'd7) begin
                     state_r <= ST_STOP;
                     txd_r   <= 1'b1;
                  end else begin
                     bit_idx_r <= bit_idx_r + 3'd1;
                     txd_r     <= shift_r[1];
                     shift_r   <= {1'b0, shift_r[7:1]};
                  end
               end else begin
                  bit_cnt_r <= bit_cnt_r - 16'd1;
               end
            end
            ST_STOP: begin
               if (bit_cnt_r == 16'd0) begin
                  if (pop_s) begin
                     shift_r   <= fifo_dout_s;
                     bit_cnt_r <= div_r - 16'd1;
                     txd_r     <= 1'b0;
                     state_r   <= ST_START;
                  end else begin
                     txd_r   <= 1'b1;
                     state_r <= ST_IDLE;
                  end
               end else begin
                  bit_cnt_r <= bit_cnt_r - 16'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               txd_r   <= 1'b1;
            end
         endcase
      end
   end

   // Control/status registers and the registered interrupt.
   always_ff @(posedge clk_in) begin
      if (!sys_rstn) begin
         div_r     <= DIV_RESET;
         ie_r      <= 1'b0;
         overrun_r <= 1'b0;
         irq_r     <= 1'b0;
      end else begin
         if (TX_WE) begin
            case (reg_sel_s)
               REG_DATA: begin
                  if (fifo_full_s) begin
                     overrun_r <= 1'b1;
                  end
               end
               REG_STATUS: overrun_r <= 1'b0;
               REG_DIV:    div_r     <= clamp_div(TX_WriteData[15:0]);
               REG_CTRL:   ie_r      <= TX_WriteData[0];
               default:    overrun_r <= overrun_r;
            endcase
         end
         irq_r <= ie_r && fifo_empty_s && (state_r == ST_IDLE);
      end
   end

   // Combinational register read for the Bridge.
   always_comb begin
      rd_data_s = 32'd0;
      case (reg_sel_s)
         REG_STATUS: begin
            rd_data_s[STAT_BUSY]                = (state_r != ST_IDLE);
            rd_data_s[STAT_FULL]                = fifo_full_s;
            rd_data_s[STAT_EMPTY]               = fifo_empty_s;
            rd_data_s[STAT_OVERRUN]             = overrun_r;
            rd_data_s[STAT_COUNT_LSB +: CW]     = fifo_count_s;
         end
         REG_DIV:  rd_data_s = {16'd0, div_r};
         REG_CTRL: rd_data_s = {31'd0, ie_r};
         default:  rd_data_s = 32'd0;
      endcase
   end

endmodule
